// File: rtl/clock24_pkg.sv
// Shared constants and types for the clock24 timekeeping core.
package clock24_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned SEC_T_MAX        = 5;
  localparam int unsigned MIN_T_MAX        = 5;
  localparam int unsigned UNIT_MAX         = 9;
  localparam int unsigned HOUR_T_MAX       = 2;
  localparam int unsigned HOUR_U_MAX_AT_20 = 3;

  typedef logic [DIGIT_W-1:0] bcd_t;

  // Full time-of-day as six BCD digits, hours tens in the MSBs.
  typedef struct packed {
    bcd_t ht;
    bcd_t hu;
    bcd_t mt;
    bcd_t mu;
    bcd_t st;
    bcd_t su;
  } time_t;

  localparam time_t RESET_TIME = '0;

endpackage

// File: rtl/clock24_counter_bcd_mod60.sv
// Two-digit BCD modulo-60 counter (00..59) with increment, clear and carry-out.
module bcd_mod60
  import clock24_pkg::*;
#(
  parameter int unsigned           TENS_MAX  = SEC_T_MAX,
  parameter logic [DIGIT_W-1:0]    RST_TENS  = '0,
  parameter logic [DIGIT_W-1:0]    RST_UNITS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] units,
  output logic               carry_c
);

  localparam logic [DIGIT_W-1:0] T_MAX = DIGIT_W'(TENS_MAX);
  localparam logic [DIGIT_W-1:0] U_MAX = DIGIT_W'(UNIT_MAX);

  logic [DIGIT_W-1:0] tens_q, tens_d;
  logic [DIGIT_W-1:0] units_q, units_d;
  logic               at_max;

  // Next count: clear dominates increment; carry only on an accepted 59->00 step.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    at_max  = (tens_q == T_MAX) && (units_q == U_MAX);
    carry_c = inc && !clr && at_max;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (units_q == U_MAX) begin
        units_d = '0;
        tens_d  = at_max ? '0 : tens_q + DIGIT_W'(1);
      end else begin
        units_d = units_q + DIGIT_W'(1);
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q  <= RST_TENS;
      units_q <= RST_UNITS;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign tens  = tens_q;
  assign units = units_q;

endmodule

// File: rtl/clock24_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler and manual set inputs.
// Optional alarm comparator enabled by defining CLOCK24_ALARM_EN.
module clock24_counter
  import clock24_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               EN,
  input  logic               SET_MIN,
  input  logic               SET_HOUR,
  output logic [DIGIT_W-1:0] HT,
  output logic [DIGIT_W-1:0] HU,
  output logic [DIGIT_W-1:0] MT,
  output logic [DIGIT_W-1:0] MU,
  output logic [DIGIT_W-1:0] ST,
  output logic [DIGIT_W-1:0] SU,
  output logic               SEC_TICK
`ifdef CLOCK24_ALARM_EN
  ,
  input  logic               ALM_ON,
  input  logic [7:0]         ALM_HOUR,
  input  logic [7:0]         ALM_MIN,
  output logic               ALARM
`endif
);

  localparam int unsigned        PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [DIGIT_W-1:0] HT_MAX    = DIGIT_W'(HOUR_T_MAX);
  localparam logic [DIGIT_W-1:0] HU_MAX20  = DIGIT_W'(HOUR_U_MAX_AT_20);
  localparam logic [DIGIT_W-1:0] U_MAX     = DIGIT_W'(UNIT_MAX);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DIGIT_W-1:0] ht_q, ht_d;
  logic [DIGIT_W-1:0] hu_q, hu_d;
  logic               sec_tick_q, sec_tick_d;
  logic               set_any;
  logic               tick;
  logic               sec_inc;
  logic               sec_carry;
  logic               min_inc;
  logic               min_carry;
  logic               hour_inc;
  logic [DIGIT_W-1:0] st, su, mt, mu;

  // Prescaler next state and tick qualification; any SET restarts the second.
  always_comb begin
    presc_d    = presc_q;
    set_any    = SET_MIN || SET_HOUR;
    tick       = EN && (presc_q == PRESC_MAX);
    sec_inc    = tick && !set_any;
    sec_tick_d = sec_inc;
    if (set_any) begin
      presc_d = '0;
    end else if (EN) begin
      presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  // Seconds: cleared by either SET, advanced only by an accepted tick.
  bcd_mod60 #(
    .TENS_MAX  (SEC_T_MAX),
    .RST_TENS  (RESET_TIME.st),
    .RST_UNITS (RESET_TIME.su)
  ) u_sec (
    .clk     (CLK),
    .rst_n   (RSTN),
    .inc     (sec_inc),
    .clr     (set_any),
    .tens    (st),
    .units   (su),
    .carry_c (sec_carry)
  );

  assign min_inc = SET_MIN || sec_carry;

  // Minutes: manual advance wraps without carrying; only a seconds carry ripples on.
  bcd_mod60 #(
    .TENS_MAX  (MIN_T_MAX),
    .RST_TENS  (RESET_TIME.mt),
    .RST_UNITS (RESET_TIME.mu)
  ) u_min (
    .clk     (CLK),
    .rst_n   (RSTN),
    .inc     (min_inc),
    .clr     (1'b0),
    .tens    (mt),
    .units   (mu),
    .carry_c (min_carry)
  );

  // Hours next state: 00..23 with the 23->00 wrap.
  always_comb begin
    ht_d     = ht_q;
    hu_d     = hu_q;
    hour_inc = SET_HOUR || (sec_carry && min_carry);
    if (hour_inc) begin
      if ((ht_q == HT_MAX) && (hu_q == HU_MAX20)) begin
        ht_d = '0;
        hu_d = '0;
      end else if (hu_q == U_MAX) begin
        hu_d = '0;
        ht_d = ht_q + DIGIT_W'(1);
      end else begin
        hu_d = hu_q + DIGIT_W'(1);
      end
    end
  end

  // Prescaler, hour digits and seconds pulse registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      presc_q    <= '0;
      ht_q       <= RESET_TIME.ht;
      hu_q       <= RESET_TIME.hu;
      sec_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      ht_q       <= ht_d;
      hu_q       <= hu_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign HT       = ht_q;
  assign HU       = hu_q;
  assign MT       = mt;
  assign MU       = mu;
  assign ST       = st;
  assign SU       = su;
  assign SEC_TICK = sec_tick_q;

`ifdef CLOCK24_ALARM_EN
  logic alarm_q, alarm_d;

  // Alarm match against the registered hours and minutes.
  always_comb begin
    alarm_d = ALM_ON && ({ht_q, hu_q} == ALM_HOUR) && ({mt, mu} == ALM_MIN);
  end

  // Alarm output register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`endif

endmodule
